// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide with sign fix-up).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 dz,
    output logic                 ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic            dz_p, ovf_p;

    logic [2*WIDTH-1:0] n_mag;
    logic [WIDTH-1:0]   d_mag;
    logic               ld_dz, ld_ovf;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   next_rem, next_quo;
    logic [WIDTH-1:0]   fin_q, fin_r;
    logic               fin_ovf;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q_r, neg_r_r;
    logic [WIDTH-1:0] lim;

    always_comb begin
        n_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
        d_mag = divisor[WIDTH-1] ? -divisor : divisor;
    end

    // A negative result may reach -2^(W-1); a positive one tops out one lower.
    always_comb begin
        lim     = neg_q_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        fin_ovf = quo_r > lim;
        fin_q   = fin_ovf ? '1 : (neg_q_r ? -quo_r : quo_r);
        fin_r   = fin_ovf ? '0 : (neg_r_r ? -rem_r : rem_r);
    end
`else
    always_comb begin
        n_mag   = dividend;
        d_mag   = divisor;
        fin_ovf = 1'b0;
        fin_q   = quo_r;
        fin_r   = rem_r;
    end
`endif

    // High half >= divisor means the quotient cannot fit, so no iterations are needed.
    always_comb begin
        ld_dz  = (divisor == '0);
        ld_ovf = !ld_dz && (n_mag[2*WIDTH-1:WIDTH] >= d_mag);
    end

    // Result of a successful trial is < divisor, so a WIDTH-bit subtract suffices.
    always_comb begin
        trial    = {rem_r, quo_r[WIDTH-1]};
        fits     = trial >= {1'b0, dvs_r};
        next_rem = fits ? (trial[WIDTH-1:0] - dvs_r) : trial[WIDTH-1:0];
        next_quo = {quo_r[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            dz_p      <= 1'b0;
            ovf_p     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        dz    <= 1'b0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                        rem_r <= n_mag[2*WIDTH-1:WIDTH];
                        // On divide-by-zero the raw low half is the reported remainder.
                        quo_r <= ld_dz ? dividend[WIDTH-1:0] : n_mag[WIDTH-1:0];
                        dvs_r <= d_mag;
                        dz_p  <= ld_dz;
                        ovf_p <= ld_ovf;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_r <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_r <= dividend[2*WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    if (dz_p || ovf_p) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        dz        <= dz_p;
                        ovf       <= ovf_p;
                        quotient  <= '1;
                        remainder <= dz_p ? quo_r : '0;
                    end else if (cnt == CW'(WIDTH)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        dz        <= 1'b0;
                        ovf       <= fin_ovf;
                        quotient  <= fin_q;
                        remainder <= fin_r;
                    end else begin
                        rem_r <= next_rem;
                        quo_r <= next_quo;
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider; expected results come from native 64-bit arithmetic.
module tb_seq_divider;
    localparam int W = 32;
    localparam longint QMAX = 64'sh7FFFFFFF;
    localparam longint QMIN = -64'sh80000000;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy, done, dz, ovf;
    logic [W-1:0]   quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .dz(dz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [63:0] n, input logic [31:0] d,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic edz, output logic eovf, output int elat);
        edz = 1'b0; eovf = 1'b0; q = '0; r = '0; elat = 33;
`ifdef SEQ_DIVIDER_SIGNED_EN
        begin
            logic [63:0] an;
            logic [31:0] ad;
            longint sn, sd, qq, rr;
            an = n[63] ? -n : n;
            ad = d[31] ? -d : d;
            if (d == 0) begin
                edz = 1'b1; q = '1; r = n[31:0]; elat = 1;
            end else if (an[63:32] >= ad) begin
                eovf = 1'b1; q = '1; r = '0; elat = 1;
            end else begin
                sn = $signed(n);
                sd = longint'($signed(d));
                qq = sn / sd;
                rr = sn % sd;
                if (qq > QMAX || qq < QMIN) begin
                    eovf = 1'b1; q = '1; r = '0;
                end else begin
                    q = qq[31:0]; r = rr[31:0];
                end
            end
        end
`else
        if (d == 0) begin
            edz = 1'b1; q = '1; r = n[31:0]; elat = 1;
        end else if (n[63:32] >= d) begin
            eovf = 1'b1; q = '1; r = '0; elat = 1;
        end else begin
            q = 32'(n / {32'b0, d});
            r = 32'(n % {32'b0, d});
        end
`endif
    endtask

    // Waits for done (bounded); lat counts edges since acceptance, entered with lat already set.
    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_div(input string tag, input logic [63:0] n, input logic [31:0] d);
        logic [31:0] eq, er;
        logic        edz, eovf, busy_ok;
        int          elat, lat;
        model(n, d, eq, er, edz, eovf, elat);
        @(negedge clk);
        start = 1'b1; dividend = n; divisor = d;
        @(negedge clk);
        start = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
        lat = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(elat));
        chk({tag, ".q"}, 64'(quotient), 64'(eq));
        chk({tag, ".r"}, 64'(remainder), 64'(er));
        chk({tag, ".dz"}, 64'(dz), 64'(edz));
        chk({tag, ".ovf"}, 64'(ovf), 64'(eovf));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        if (elat > 1) chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".q_hold"}, 64'(quotient), 64'(eq));
    endtask

    initial begin
        int          lat;
        logic        saw;
        logic [63:0] n;
        logic [31:0] d;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.q", 64'(quotient), 64'd0);
        chk("rst.r", 64'(remainder), 64'd0);
        chk("rst.dz", 64'(dz), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        rst = 1'b0;

        do_div("d100_7", 64'd100, 32'd7);
        do_div("dz", 64'h12345678, 32'd0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        do_div("sneg7_2", -64'sd7, 32'd2);
        do_div("s7_neg2", 64'd7, -32'sd2);
        do_div("sneg100_neg7", -64'sd100, -32'sd7);
        do_div("s_posmax_ovf", 64'h80000000, 32'd1);
        do_div("s_negmin_ok", -64'sh80000000, 32'd1);
        do_div("s_early_ovf", 64'h00000001_00000000, 32'd1);
`else
        do_div("max_sq", 64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
        do_div("early_ovf", 64'h00000001_00000000, 32'd1);
        do_div("hi_eq_d", 64'h00000007_00000000, 32'd7);
`endif

        // Start pulsed mid-run must not disturb the division in flight.
        @(negedge clk);
        start = 1'b1; dividend = 64'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0; lat = 0;
        repeat (5) @(negedge clk);
        lat += 5;
        start = 1'b1; dividend = 64'd1000; divisor = 32'd3;
        @(negedge clk);
        lat++;
        start = 1'b0;
        wait_done(lat);
        chk("midstart.lat", 64'(lat), 64'd33);
        chk("midstart.q", 64'(quotient), 64'd14);
        chk("midstart.r", 64'(remainder), 64'd2);
        // Start presented while done is high is dropped.
        start = 1'b1; dividend = 64'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("donestart.busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("donestart.q", 64'(quotient), 64'd14);

        // Mid-run reset aborts with no done pulse.
        start = 1'b1; dividend = 64'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.q", 64'(quotient), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        chk("midrst.no_done", 64'(saw), 64'd0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; dividend = 64'd9; divisor = 32'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio.busy", 64'(busy), 64'd0);

        for (int i = 0; i < 24; i++) begin
            n = {$urandom, $urandom};
            d = $urandom;
            if (d == 0) d = 32'd1;
            case (i % 4)
                0: d = 32'd0;
                1: ;
                default: begin
                    n[63:32] = n[63:32] % d;
                    if ($urandom_range(0, 1) == 1) n = -n;
                end
            endcase
            do_div($sformatf("rnd%0d", i), n, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
